// File: rtl/div_radix.sv
// Iterative RV32M-style divider (DIV/DIVU/REM/REMU).
// Uses restoring division with BITS_PER_CYCLE steps per cycle, and has an early-out for divide-by-zero and signed overflow.
module div_radix #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int RADDR_W        = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    dividend_i,
  input  logic [XLEN-1:0]    divisor_i,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [RADDR_W-1:0] reg_waddr_i,
  input  logic               flush_i,
  output logic [XLEN-1:0]    result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic [RADDR_W-1:0] reg_waddr_o
);

  localparam int NCYC = XLEN / BITS_PER_CYCLE;
  localparam int CW   = $clog2(NCYC + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PREP    = 3'd1;
  localparam logic [2:0] S_CALC    = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic [2:0]         r_state;
  logic [XLEN-1:0]    r_a;
  logic [XLEN-1:0]    r_b;
  logic               r_uns;
  logic               r_rem_op;
  logic [RADDR_W-1:0] r_waddr;
  logic [XLEN:0]      r_rem;
  logic [XLEN-1:0]    r_quo;
  logic [XLEN-1:0]    r_dvs;
  logic [CW-1:0]      r_cnt;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [XLEN-1:0]    r_result;

  // op_i[2] only marks the M-extension divide group and carries no information here
  logic w_unused_op;
  assign w_unused_op = op_i[2];

  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_div_zero;
  logic            w_ovf;
  logic [XLEN-1:0] w_special;

  assign w_abs_a    = (!r_uns && r_a[XLEN-1]) ? (~r_a + 1'b1) : r_a;
  assign w_abs_b    = (!r_uns && r_b[XLEN-1]) ? (~r_b + 1'b1) : r_b;
  assign w_div_zero = (r_b == '0);
  assign w_ovf      = !r_uns && (r_a == {1'b1, {(XLEN-1){1'b0}}}) && (r_b == '1);
  assign w_special  = r_rem_op ? (w_div_zero ? r_a : '0)
                               : (w_div_zero ? '1  : r_a);

  // Chain of restoring steps: quotient register shifts the dividend out and the quotient bits in
  logic [XLEN:0]   w_rem_c [0:BITS_PER_CYCLE];
  logic [XLEN-1:0] w_quo_c [0:BITS_PER_CYCLE];

  assign w_rem_c[0] = r_rem;
  assign w_quo_c[0] = r_quo;

  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
      logic [XLEN:0] w_sh;
      logic [XLEN:0] w_diff;
      assign w_sh   = {w_rem_c[gi][XLEN-1:0], w_quo_c[gi][XLEN-1]};
      assign w_diff = w_sh - {1'b0, r_dvs};
      assign w_rem_c[gi+1] = w_diff[XLEN] ? w_sh : w_diff;
      assign w_quo_c[gi+1] = {w_quo_c[gi][XLEN-2:0], ~w_diff[XLEN]};
    end
  endgenerate

  logic [XLEN-1:0] w_q_mag;
  logic [XLEN-1:0] w_r_mag;
  logic [XLEN-1:0] w_q_fin;
  logic [XLEN-1:0] w_r_fin;

  assign w_q_mag = w_quo_c[BITS_PER_CYCLE];
  assign w_r_mag = w_rem_c[BITS_PER_CYCLE][XLEN-1:0];
  assign w_q_fin = r_neg_q ? (~w_q_mag + 1'b1) : w_q_mag;
  assign w_r_fin = r_neg_r ? (~w_r_mag + 1'b1) : w_r_mag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_uns    <= 1'b0;
      r_rem_op <= 1'b0;
      r_waddr  <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (flush_i && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            r_a      <= dividend_i;
            r_b      <= divisor_i;
            r_uns    <= op_i[0];
            r_rem_op <= op_i[1];
            r_waddr  <= reg_waddr_i;
            r_state  <= S_PREP;
          end
        end
        S_PREP: begin
          if (w_div_zero || w_ovf) begin
            r_result <= w_special;
            r_state  <= S_DONE;
          end else begin
            r_rem   <= '0;
            r_quo   <= w_abs_a;
            r_dvs   <= w_abs_b;
            r_cnt   <= '0;
            r_neg_q <= !r_uns && (r_a[XLEN-1] ^ r_b[XLEN-1]);
            r_neg_r <= !r_uns && r_a[XLEN-1];
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_c[BITS_PER_CYCLE];
          r_quo <= w_quo_c[BITS_PER_CYCLE];
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(NCYC - 1)) begin
            r_result <= r_rem_op ? w_r_fin : w_q_fin;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_RELEASE;
        end
        S_RELEASE: begin
          if (!start_i) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready_o     = (r_state == S_DONE);
  assign busy_o      = (r_state == S_CALC);
  assign result_o    = ready_o ? r_result : '0;
  assign reg_waddr_o = ready_o ? r_waddr : '0;

endmodule
